// File: rtl/dispatcher_pkg.sv
// Shared types and helpers for the dispatcher_n packet dispatcher.
//   disp_state_t : packet FSM state (IDLE / ROUTE / DROP)
//   DEST_ANY     : all-ones destination, sliced to DEST_W by the user
//   dest_valid() : true when a destination addresses an existing tile
package dispatcher_pkg;

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} disp_state_t;

    localparam logic [31:0] DEST_ANY = '1;

    function automatic logic dest_valid(input logic [31:0] dest, input int unsigned n_tiles);
        return dest < n_tiles;
    endfunction

endpackage

// File: rtl/dispatcher_skid.sv
// Two-entry AXI-Stream skid buffer in front of the dispatcher FSM.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_data     : upstream beat
//   in_ready             : registered "not full"; low during reset
//   out_valid/out_data   : oldest buffered beat
//   out_pop              : consumer takes the oldest beat this cycle
module dispatcher_skid #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_pop
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic         rdy_q, rdy_d;
    logic         push, pop;

    assign push      = in_valid & rdy_q;
    assign pop       = out_pop & (cnt_q != 2'd0);
    assign in_ready  = rdy_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = e0_q;

    // e0 is always the head; a pop shifts e1 down.
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = in_data;
                else               e1_d = in_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = in_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = in_data;
                end
            end
            default: ;
        endcase
        // Ready is exact, not conservative: it reflects the occupancy after this edge.
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            e0_q  <= '0;
            e1_q  <= '0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            rdy_q <= rdy_d;
        end
    end

endmodule

// File: rtl/dispatcher_n.sv
// Parametrised packet dispatcher: one AXI-Stream ingress steered per packet
// to one of N_TILES egress streams by the destination field of the head beat.
//   clk_line, clk_line_rst_low : line clock, asynchronous active-low reset
//   stream_in_packet_*         : ingress AXI-Stream (TREADY registered)
//   stream_out_packet_*        : egress; TDATA/TKEEP/TLAST broadcast, TVALID only on sel
//   drop_count                 : saturating count of dropped packets
//   busy                       : a packet is in flight (FSM not IDLE)
// Optional feature macro DISPATCH_RR_EN: all-ones destination (ANY) is sent
// round-robin; without it ANY packets are dropped.
module dispatcher_n
    import dispatcher_pkg::*;
#(
    parameter int N_TILES  = 4,
    parameter int BW       = 32,
    parameter int BWB      = 4,
    parameter int DEST_LSB = 0,
    parameter int DEST_W   = 6
) (
    input  logic                   clk_line,
    input  logic                   clk_line_rst_low,
    input  logic                   stream_in_packet_TVALID,
    input  logic [BW-1:0]          stream_in_packet_TDATA,
    input  logic [BWB-1:0]         stream_in_packet_TKEEP,
    input  logic                   stream_in_packet_TLAST,
    output logic                   stream_in_packet_TREADY,
    output logic [N_TILES-1:0]     stream_out_packet_TVALID,
    output logic [N_TILES*BW-1:0]  stream_out_packet_TDATA,
    output logic [N_TILES*BWB-1:0] stream_out_packet_TKEEP,
    output logic [N_TILES-1:0]     stream_out_packet_TLAST,
    input  logic [N_TILES-1:0]     stream_out_packet_TREADY,
    output logic [15:0]            drop_count,
    output logic                   busy
);

    localparam int SEL_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int PW    = BW + BWB + 1;

    logic          skid_vld, skid_pop;
    logic [PW-1:0] skid_data;
    logic [BW-1:0] sk_tdata;
    logic [BWB-1:0] sk_tkeep;
    logic          sk_tlast;

    assign {sk_tlast, sk_tkeep, sk_tdata} = skid_data;

    dispatcher_skid #(.W(PW)) u_skid (
        .clk       (clk_line),
        .rst_n     (clk_line_rst_low),
        .in_valid  (stream_in_packet_TVALID),
        .in_data   ({stream_in_packet_TLAST, stream_in_packet_TKEEP, stream_in_packet_TDATA}),
        .in_ready  (stream_in_packet_TREADY),
        .out_valid (skid_vld),
        .out_data  (skid_data),
        .out_pop   (skid_pop)
    );

    disp_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             out_vld_q, out_vld_d;
    logic [BW-1:0]    out_data_q, out_data_d;
    logic [BWB-1:0]   out_keep_q, out_keep_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      drop_q, drop_d;

    logic [DEST_W-1:0] dest;
    logic              out_fire, head_slot, head_route;
    logic [SEL_W-1:0]  head_sel;

    assign dest     = sk_tdata[DEST_LSB +: DEST_W];
    assign out_fire = out_vld_q & stream_out_packet_TREADY[sel_q];
    // A new head may be decided in IDLE, or in ROUTE on the very cycle the
    // current packet's last beat is taken, so back-to-back packets see no bubble.
    assign head_slot = (state_q == IDLE) | ((state_q == ROUTE) & out_fire & out_last_q);

`ifdef DISPATCH_RR_EN
    logic             any_q, any_d, head_any, rr_adv;
    logic [SEL_W-1:0] rr_q, rr_cur;

    assign rr_adv = out_fire & out_last_q & any_q;
    // Bypass the advance so a head decided in the same cycle uses the new pointer.
    assign rr_cur = !rr_adv ? rr_q :
                    (rr_q == SEL_W'(N_TILES - 1)) ? '0 : rr_q + 1'b1;
`endif

    always_comb begin
        head_route = 1'b0;
        head_sel   = '0;
`ifdef DISPATCH_RR_EN
        head_any   = 1'b0;
`endif
        if (dest_valid(32'(dest), N_TILES)) begin
            head_route = 1'b1;
            head_sel   = dest[SEL_W-1:0];
        end
`ifdef DISPATCH_RR_EN
        else if (dest == DEST_ANY[DEST_W-1:0]) begin
            head_route = 1'b1;
            head_sel   = rr_cur;
            head_any   = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        drop_d     = drop_q;
        skid_pop   = 1'b0;
`ifdef DISPATCH_RR_EN
        any_d      = any_q;
`endif
        if (out_fire) out_vld_d = 1'b0;
        if ((state_q == ROUTE) && out_fire && out_last_q) state_d = IDLE;

        case (state_q)
            IDLE, ROUTE: begin
                if (skid_vld && head_slot) begin
                    skid_pop = 1'b1;
                    if (head_route) begin
                        out_vld_d  = 1'b1;
                        out_data_d = sk_tdata;
                        out_keep_d = sk_tkeep;
                        out_last_d = sk_tlast;
                        sel_d      = head_sel;
                        state_d    = ROUTE;
`ifdef DISPATCH_RR_EN
                        any_d      = head_any;
`endif
                    end else begin
                        drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                        state_d = sk_tlast ? IDLE : DROP;
                    end
                end else if (skid_vld && (state_q == ROUTE) &&
                             (!out_vld_q || (out_fire && !out_last_q))) begin
                    // Body beat; the last beat of the packet is never followed
                    // by another body pop because it blocks until taken.
                    skid_pop   = 1'b1;
                    out_vld_d  = 1'b1;
                    out_data_d = sk_tdata;
                    out_keep_d = sk_tkeep;
                    out_last_d = sk_tlast;
                end
            end
            DROP: begin
                if (skid_vld) begin
                    skid_pop = 1'b1;
                    if (sk_tlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            drop_q     <= drop_d;
        end
    end

`ifdef DISPATCH_RR_EN
    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            rr_q  <= '0;
            any_q <= 1'b0;
        end else begin
            rr_q  <= rr_cur;
            any_q <= any_d;
        end
    end
`endif

    assign stream_out_packet_TVALID = out_vld_q ? (N_TILES'(1) << sel_q) : '0;
    assign stream_out_packet_TDATA  = {N_TILES{out_data_q}};
    assign stream_out_packet_TKEEP  = {N_TILES{out_keep_q}};
    assign stream_out_packet_TLAST  = {N_TILES{out_last_q}};
    assign drop_count               = drop_q;
    assign busy                     = (state_q != IDLE);

endmodule
